uart_tx: RTL and testbench

- 8N1 UART transmitter with an input byte FIFO. Serialises bytes onto a single TX line.
- Sits directly downstream of the design's byte source: the received/processed byte stream feeds data_i. tx_o drives the top-level tx pin.
- Matches the receiver's line format: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Default 9600 baud at 50 MHz.

---
 rtl/uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; tx_o idles high and frames are sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 9600,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_reg, baud_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] head;
  logic       push, load, baud_end;

  assign ready_o      = (count_reg < COUNT_FULL);
  assign push         = valid_i && ready_o;
  assign head         = mem[rd_ptr_reg];
  assign baud_end     = (baud_reg == BAUD_LAST);
  assign tx_o         = tx_reg;
  assign busy_o       = busy_reg;
  assign fifo_count_o = count_reg;

  // FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = S_DATA;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = S_STOP;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (count_reg != '0) load = 1'b1;
          else                 state_next = S_IDLE;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Loading from IDLE or from the end of STOP both start a fresh frame.
    if (load) begin
      state_next = S_START;
      baud_next  = '0;
      shift_next = head;
`ifdef UART_TX_PARITY_EN
      parity_next = ^head;
`endif
    end

    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase

    count_next = count_reg;
    case ({push, load})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase

    busy_next = (state_next != S_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= 3'd0;
      shift_reg  <= 8'h00;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (load) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: DIV=10 instance for framing/FIFO/reset cases, default-parameter instance for bit timing.
// Expected line levels come from a per-segment bit table built from the pushed byte.
module tb_uart_tx;

  localparam int DIV     = 10;
  localparam int CW      = $clog2(8) + 1;
  localparam int DEF_DIV = 50000000 / 9600;
`ifdef UART_TX_PARITY_EN
  localparam int NSEG = 11;
`else
  localparam int NSEG = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          valid = 1'b0;
  logic          ready, tx, busy;
  logic [CW-1:0] count;

  logic [7:0]    data_def = 8'h00;
  logic          valid_def = 1'b0;
  logic          ready_def, tx_def, busy_def;
  logic [CW-1:0] count_def;

  int checks = 0;
  int errors = 0;
  int first_count;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .FIFO_DEPTH(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .fifo_count_o(count)
  );

  uart_tx u_dut_def (
    .clk_i(clk), .rst_i(rst), .data_i(data_def), .valid_i(valid_def),
    .ready_o(ready_def), .tx_o(tx_def), .busy_o(busy_def), .fifo_count_o(count_def)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Segment 0 start, 1..8 data LSB first, then parity (if enabled) and stop.
  function automatic logic exp_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks the next NSEG*DIV negedge samples against the frame for b.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    int errs;
    for (int s = 0; s < NSEG; s++) begin
      errs = 0;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (s == 0 && c == 0) first_count = int'(count);
        if (tx !== exp_bit(b, s)) errs++;
      end
      chk($sformatf("%s seg%0d", tag, s), errs, 0);
    end
    $display("frame %s byte %02h checked", tag, b);
  endtask

  initial begin
    int lows, run, busy_hi;
    logic [7:0] rx;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst tx", int'(tx), 1);
    chk("rst ready", int'(ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst count", int'(count), 0);
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");

    // Single byte 0x81
    data = 8'h81; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("single count after push", int'(count), 1);
    chk("single tx after push", int'(tx), 1);
    chk("single busy after push", int'(busy), 1);
    expect_frame(8'h81, "single");
    chk("single count after load", first_count, 0);
    chk("single busy last stop", int'(busy), 1);
    @(negedge clk);
    chk("single busy end", int'(busy), 0);
    chk("single tx end", int'(tx), 1);

    // Back-to-back 0x81, 0xAA, 0x01
    data = 8'h81; valid = 1'b1;
    @(negedge clk);
    fork
      begin
        data = 8'hAA;
        @(negedge clk);
        data = 8'h01;
        @(negedge clk);
        valid = 1'b0;
      end
      begin
        expect_frame(8'h81, "b2b0");
        expect_frame(8'hAA, "b2b1");
        expect_frame(8'h01, "b2b2");
      end
    join
    @(negedge clk);
    chk("b2b busy end", int'(busy), 0);

    // Overflow: 0x00..0x09 offered on consecutive cycles, 0x09 dropped
    data = 8'h00; valid = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int k = 1; k < 10; k++) begin
          if (k == 9) begin
            chk("ovf ready full", int'(ready), 0);
            chk("ovf count full", int'(count), 8);
          end
          data = 8'(k);
          @(negedge clk);
        end
        chk("ovf count after drop", int'(count), 8);
        valid = 1'b0;
      end
      begin
        for (int k = 0; k < 9; k++) expect_frame(8'(k), $sformatf("ovf%0d", k));
      end
    join
    @(negedge clk);
    chk("ovf busy end", int'(busy), 0);
    chk("ovf count end", int'(count), 0);
    chk("ovf tx end", int'(tx), 1);

    // Parity-sensitive bytes (plain 8N1 frames when parity is disabled)
    data = 8'h07; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    expect_frame(8'h07, "par07");
    @(negedge clk);
    data = 8'h03; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    expect_frame(8'h03, "par03");
    @(negedge clk);
    chk("par busy end", int'(busy), 0);

    // Reset during data bit 3 of 0xAA with 0x55 still queued
    data = 8'hAA; valid = 1'b1;
    @(negedge clk);
    data = 8'h55;
    @(negedge clk);
    valid = 1'b0;
    chk("midrst tx start", int'(tx), 0);
    repeat (44) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst tx", int'(tx), 1);
    chk("midrst count", int'(count), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst ready", int'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0; busy_hi = 0;
    for (int i = 0; i < 2 * NSEG * DIV; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
    end
    chk("midrst quiet tx", lows, 0);
    chk("midrst quiet busy", busy_hi, 0);
    data = 8'h3C; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    expect_frame(8'h3C, "postrst");
    @(negedge clk);
    chk("postrst busy end", int'(busy), 0);

    // Default parameters: 0x55, bit period DEF_DIV clocks
    data_def = 8'h55; valid_def = 1'b1;
    @(negedge clk);
    valid_def = 1'b0;
    run = 0;
    while (tx_def !== 1'b0 && run < 10) begin
      @(negedge clk);
      run++;
    end
    chk("def latency", run, 1);
    run = 1;
    while (tx_def === 1'b0 && run < 6000) begin
      @(negedge clk);
      if (tx_def === 1'b0) run++;
    end
    chk("def start len", run, DEF_DIV);
    rx = 8'h00;
    rx[0] = tx_def;
    run = 1;
    while (tx_def === 1'b1 && run < 6000) begin
      @(negedge clk);
      if (tx_def === 1'b1) run++;
    end
    chk("def bit0 len", run, DEF_DIV);
    repeat (DEF_DIV / 2) @(negedge clk);
    rx[1] = tx_def;
    for (int i = 2; i < 8; i++) begin
      repeat (DEF_DIV) @(negedge clk);
      rx[i] = tx_def;
    end
    chk("def rx byte", int'(rx), 8'h55);
    for (int s = 9; s < NSEG; s++) begin
      repeat (DEF_DIV) @(negedge clk);
      chk($sformatf("def seg%0d", s), int'(tx_def), int'(exp_bit(8'h55, s)));
    end
    $display("default-rate frame rx %02h", rx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
